// File: rtl/div_sequencer.sv
`default_nettype none
// div_sequencer: RV32M DIV/DIVU/REM/REMU sequencer with an iterative radix-2 restoring divider. Rev 1.0
// Optional macro DIV_EARLY_OUT_EN: skip iteration when |a| < |b|.
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rdo_q, rdo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  logic            is_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Before PREP, quo_q holds the raw dividend and b_q the raw divisor.
  assign is_signed = ~op_q[0];
  assign a_abs     = (is_signed && quo_q[XLEN-1]) ? (~quo_q + 1'b1) : quo_q;
  assign b_abs     = (is_signed && b_q[XLEN-1])   ? (~b_q + 1'b1)   : b_q;
  assign rem_sh    = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign rem_ge    = (rem_sh >= {1'b0, b_q});
  assign quo_fix   = negq_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix   = negr_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    quo_d    = quo_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rdo_d    = rdo_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d  = op_i;
          rd_d  = rd_i;
          quo_d = a_i;
          b_d   = b_i;
          if (b_i == '0) begin
            state_d  = S_DONE;
            result_d = op_i[1] ? a_i : '1;
            rdo_d    = rd_i;
          end else if (!op_i[0] && (a_i == MIN_NEG) && (b_i == '1)) begin
            state_d  = S_DONE;
            result_d = op_i[1] ? '0 : MIN_NEG;
            rdo_d    = rd_i;
          end else begin
            state_d = S_PREP;
          end
        end
      end
      S_PREP: begin
        negq_d  = is_signed & (quo_q[XLEN-1] ^ b_q[XLEN-1]);
        negr_d  = is_signed & quo_q[XLEN-1];
        quo_d   = a_abs;
        b_d     = b_abs;
        rem_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = S_ITER;
`ifdef DIV_EARLY_OUT_EN
        if (a_abs < b_abs) begin
          quo_d   = '0;
          rem_d   = {1'b0, a_abs};
          state_d = S_FIX;
        end
`endif
      end
      S_ITER: begin
        rem_d = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        quo_d = {quo_q[XLEN-2:0], rem_ge};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = op_q[1] ? rem_fix : quo_fix;
        rdo_d    = rd_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An abort must leave the visible result untouched.
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rdo_d    = rdo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      rdo_q    <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      rdo_q    <= rdo_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign stall_o  = rst_n & (((state_q == S_IDLE) & start_i & ~flush_i) |
                             (state_q == S_PREP) | (state_q == S_ITER) | (state_q == S_FIX));
  assign done_o   = rst_n & (state_q == S_DONE);
  assign result_o = result_q;
  assign rd_o     = rdo_q;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// tb_div_sequencer: directed and randomized checks of div_sequencer against a cycle-level reference model. Rev 1.0
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic [4:0]  rd_i = 5'd0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  div_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // RV32M semantics computed with wide signed arithmetic; the overflow case falls out of truncation.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = op[0] ? longint'(a) : longint'($signed(a));
    mb = op[0] ? longint'(b) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 3;
`endif
    return 35;
  endfunction

  // Reference model: idle or busy-until-done_at, plus the held visible result.
  bit          m_known = 1'b0;
  bit          m_busy = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_pres = 32'd0, m_res = 32'd0;
  logic [4:0]  m_prd = 5'd0, m_rd = 5'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_res   = 32'd0;
      m_rd    = 5'd0;
    end else if (m_busy) begin
      if (cyc == m_done_at) begin
        m_busy = 1'b0;
        m_res  = m_pres;
        m_rd   = m_prd;
      end else if (flush_i) begin
        m_busy = 1'b0;
      end
    end else if (start_i && !flush_i) begin
      m_busy    = 1'b1;
      m_done_at = cyc + ref_latency(op_i, a_i, b_i);
      m_pres    = ref_result(op_i, a_i, b_i);
      m_prd     = rd_i;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    bit exp_stall, in_done;
    if (m_known) begin
      exp_stall = rst_n && ((m_busy && cyc < m_done_at) || (!m_busy && start_i && !flush_i));
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      if (rst_n) begin
        in_done = m_busy && (cyc == m_done_at);
        chk("done_o", 32'(done_o), 32'(in_done));
        chk("result_o", result_o, in_done ? m_pres : m_res);
        chk("rd_o", 32'(rd_o), 32'(in_done ? m_prd : m_rd));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat);
    int c0;
    bit seen;
    seen = 1'b0;
    c0 = cyc;
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no done_o within 60 cycles, expected latency %0d", nm, exp_lat);
    end else begin
      chk({nm, " latency"}, 32'(cyc - c0), 32'(exp_lat));
      chk({nm, " result"}, result_o, exp_res);
      chk({nm, " rd"}, 32'(rd_o), 32'(rd));
      tick();
    end
  endtask

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 3;
`else
  localparam int EARLY_LAT = 35;
`endif

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset result_o", result_o, 32'd0);
    chk("reset rd_o", 32'(rd_o), 32'd0);
    tick();

    do_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 35);
    do_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 35);
    do_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 35);
    do_op("DIV 123/0", 2'b00, 32'd123, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    do_op("REMU 123/0", 2'b11, 32'd123, 32'd0, 5'd9, 32'd123, 1);
    do_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1);
    do_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
    do_op("DIVU 3/10", 2'b01, 32'd3, 32'd10, 5'd12, 32'd0, EARLY_LAT);
    do_op("REMU 3/10", 2'b11, 32'd3, 32'd10, 5'd13, 32'd3, EARLY_LAT);

    // Flush mid-operation, then a fresh divide two cycles later.
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd50; b_i = 32'd5; rd_i = 5'd14;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush stall_o", 32'(stall_o), 32'd0);
    chk("flush done_o", 32'(done_o), 32'd0);
    chk("flush result_o", result_o, 32'd3);
    tick();
    do_op("DIVU 9/3 after flush", 2'b01, 32'd9, 32'd3, 5'd15, 32'd3, 35);

    // Same sequence with reset instead of flush.
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd50; b_i = 32'd5; rd_i = 5'd14;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst stall_o", 32'(stall_o), 32'd0);
    chk("rst done_o", 32'(done_o), 32'd0);
    chk("rst result_o", result_o, 32'd0);
    chk("rst rd_o", 32'(rd_o), 32'd0);
    tick();
    do_op("DIVU 9/3 after reset", 2'b01, 32'd9, 32'd3, 5'd16, 32'd3, 35);

    for (int i = 0; i < 4000; i++) begin
      rst_n   = ($urandom_range(0, 399) != 0);
      start_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 79) == 0);
      op_i    = 2'($urandom);
      rd_i    = 5'($urandom);
      case ($urandom_range(0, 7))
        0: begin a_i = $urandom; b_i = 32'd0; end
        1: begin a_i = 32'h8000_0000; b_i = 32'hFFFF_FFFF; end
        2: begin a_i = $urandom_range(0, 1000); b_i = $urandom_range(1, 50); end
        3: begin a_i = $urandom_range(0, 20); b_i = $urandom_range(21, 1000); end
        4: begin a_i = -$urandom_range(0, 1000); b_i = $urandom_range(1, 50); end
        5: begin a_i = $urandom; b_i = -$urandom_range(1, 50); end
        default: begin a_i = $urandom; b_i = $urandom; end
      endcase
      tick();
    end

    rst_n = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
